// File: rtl/instr_loader.sv
// -----------------------------------------------------------------------------
// instr_loader
//
// Program loader and writable instruction store for the 8-bit core. Decoded
// instruction fields arrive one per beat over a valid/ready stream. Each beat
// is checked for legality, encoded into an 8-bit instruction word and written
// sequentially into program memory starting at address 0. The fetch port
// (pc -> instr) reads that memory combinationally. Words at or beyond the
// current count read back as HALT (8'hE0).
//
// Parameters
//   DEPTH    program memory words (power of two, <= 65536)
//   AW       address width
//   NLABELS  number of legal jump-label indices (0 .. NLABELS-1)
//
// Ports
//   clk, reset         rising-edge clock, synchronous active-high reset
//   start              pulse: begin (or restart) a load at address 0
//   in_valid/in_ready  field-beat handshake; in_ready is high only while loading
//   in_opcode..in_last decoded instruction fields and end-of-program marker
//   done, error        sticky status of the last load
//   err_addr           address of the offending beat when error is set
//   count              words written in the current/last load
//   pc, instr          fetch port, zero latency
// -----------------------------------------------------------------------------
module instr_loader #(
  parameter int DEPTH   = 256,
  parameter int AW      = $clog2(DEPTH),
  parameter int NLABELS = 3
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [3:0]    in_opcode,
  input  logic [2:0]    in_reg_a,
  input  logic [2:0]    in_reg_o,
  input  logic [2:0]    in_imm,
  input  logic          in_flag,
  input  logic [3:0]    in_label,
  input  logic          in_last,
  output logic          done,
  output logic          error,
  output logic [AW-1:0] err_addr,
  output logic [AW:0]   count,
  input  logic [15:0]   pc,
  output logic [7:0]    instr
);

  localparam logic [3:0] OP_JMP  = 4'h2;
  localparam logic [3:0] OP_LIM  = 4'h4;
  localparam logic [3:0] OP_SFT  = 4'h9;
  localparam logic [3:0] OP_INC  = 4'hD;
  localparam logic [3:0] OP_HALT = 4'hE;
  localparam logic [3:0] OP_TBA  = 4'hF;
  localparam logic [7:0] HALT_WORD = 8'hE0;

  // Address of the final memory word; a legal beat here fills the store.
  localparam logic [AW:0] LAST_ADDR = (AW+1)'(DEPTH - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_DONE,
    S_ERR
  } state_e;

  state_e        state_q, state_d;
  logic [AW:0]   count_q, count_d;
  logic [AW-1:0] err_addr_q, err_addr_d;

  logic [7:0]    word;
  logic          legal;
  logic          accept;
  logic          we;

  logic [7:0]    mem_q [DEPTH];

  // ---------------------------------------------------------------------------
  // Field encoder and legality check
  // ---------------------------------------------------------------------------
  // NOTE: every output of a combinational block gets a default first, so no
  // path through the case can leave it unassigned and infer a latch.
  always_comb begin
    word  = '0;
    legal = 1'b0;
    case (in_opcode)
      OP_SFT, OP_INC: begin
        word  = {in_opcode, in_reg_a, in_flag};
        legal = 1'b1;
      end
      OP_LIM: begin
        // Only r2/r3 are immediate targets; the low bit selects which.
        word  = {in_opcode, in_imm, (in_reg_o == 3'd3)};
        legal = (in_reg_o[2:1] == 2'b01);
      end
      OP_JMP: begin
        word  = {in_opcode, in_label};
        legal = (32'(in_label) < NLABELS);
      end
      OP_HALT, OP_TBA: begin
        word  = {in_opcode, 4'b0000};
        legal = 1'b1;
      end
      default: begin
        // M-form: input register from r0..r3, output register from r4..r7.
        word  = {in_opcode, in_reg_a[1:0], in_reg_o[1:0]};
        legal = !in_reg_a[2] && in_reg_o[2];
      end
    endcase
  end

  // A beat presented in the same cycle as start is dropped by the restart.
  assign accept = (state_q == S_LOAD) && in_valid && !start;

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    err_addr_d = err_addr_q;
    we         = 1'b0;
    if (start) begin
      state_d    = S_LOAD;
      count_d    = '0;
      err_addr_d = '0;
    end else if (accept) begin
      if (legal) begin
        we      = 1'b1;
        count_d = count_q + 1'b1;
        if (in_last || (count_q == LAST_ADDR)) begin
          state_d = S_DONE;
        end
      end else begin
        err_addr_d = count_q[AW-1:0];
        state_d    = S_ERR;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples its _d value from before the edge, independent of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      count_q    <= '0;
      err_addr_q <= '0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      err_addr_q <= err_addr_d;
    end
  end

  // NOTE: the program memory has no reset; count_q = 0 already masks every
  // word at the fetch port, and leaving it unreset keeps it a plain RAM.
  always_ff @(posedge clk) begin
    if (we && !reset) begin
      mem_q[count_q[AW-1:0]] <= word;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign in_ready = (state_q == S_LOAD);
  assign done     = (state_q == S_DONE);
  assign error    = (state_q == S_ERR);
  assign err_addr = err_addr_q;
  assign count    = count_q;

  // Anything not yet written in this load, including pc >= DEPTH, reads HALT.
  assign instr = (32'(pc) < 32'(count_q)) ? mem_q[pc[AW-1:0]] : HALT_WORD;

endmodule

// File: tb/tb_instr_loader.sv
// -----------------------------------------------------------------------------
// tb_instr_loader
//
// Drives two loaders from the same stimulus: the default 256-word instance and
// a 4-word instance for the full-store boundary. A transaction-level model of
// each loader (word list, count, status flags) predicts every output.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_instr_loader;

  logic        clk = 1'b0;
  logic        reset, start, in_valid, in_flag, in_last;
  logic [3:0]  in_opcode, in_label;
  logic [2:0]  in_reg_a, in_reg_o, in_imm;
  logic [15:0] pc;

  logic        ready0, done0, error0;
  logic [7:0]  err_addr0;
  logic [8:0]  count0;
  logic [7:0]  instr0;

  logic        ready1, done1, error1;
  logic [1:0]  err_addr1;
  logic [2:0]  count1;
  logic [7:0]  instr1;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  instr_loader u0 (
    .clk(clk), .reset(reset), .start(start), .in_valid(in_valid), .in_ready(ready0),
    .in_opcode(in_opcode), .in_reg_a(in_reg_a), .in_reg_o(in_reg_o), .in_imm(in_imm),
    .in_flag(in_flag), .in_label(in_label), .in_last(in_last),
    .done(done0), .error(error0), .err_addr(err_addr0), .count(count0),
    .pc(pc), .instr(instr0)
  );

  instr_loader #(.DEPTH(4)) u1 (
    .clk(clk), .reset(reset), .start(start), .in_valid(in_valid), .in_ready(ready1),
    .in_opcode(in_opcode), .in_reg_a(in_reg_a), .in_reg_o(in_reg_o), .in_imm(in_imm),
    .in_flag(in_flag), .in_label(in_label), .in_last(in_last),
    .done(done1), .error(error1), .err_addr(err_addr1), .count(count1),
    .pc(pc), .instr(instr1)
  );

  // ---------------------------------------------------------------------------
  // Reference model: per instance, the list of words written this load plus
  // loading/done/error flags.
  // ---------------------------------------------------------------------------
  logic [7:0] m_mem [2][256];
  int         m_cnt   [2];
  int         m_eaddr [2];
  bit         m_load  [2];
  bit         m_done  [2];
  bit         m_err   [2];

  function automatic int depth_of(int i);
    return (i == 0) ? 256 : 4;
  endfunction

  // Instruction word from the opcode-family rules, computed arithmetically.
  function automatic int ref_word(int op, int a, int o, int imm, int f, int lbl,
                                  output bit ok);
    if (op == 9 || op == 13) begin            // SFT, INC
      ok = 1'b1;
      return op * 16 + a * 2 + f;
    end else if (op == 4) begin               // LIM
      ok = (o == 2) || (o == 3);
      return op * 16 + imm * 2 + ((o == 3) ? 1 : 0);
    end else if (op == 2) begin               // JMP
      ok = (lbl < 3);
      return op * 16 + lbl;
    end else if (op == 14 || op == 15) begin  // HALT, TBA
      ok = 1'b1;
      return op * 16;
    end else begin                            // M-form
      ok = (a < 4) && (o >= 4);
      return op * 16 + (a % 4) * 4 + (o % 4);
    end
  endfunction

  task automatic model_step();
    bit ok;
    int w;
    for (int i = 0; i < 2; i++) begin
      if (reset) begin
        m_load[i] = 0; m_done[i] = 0; m_err[i] = 0; m_eaddr[i] = 0; m_cnt[i] = 0;
      end else if (start) begin
        m_load[i] = 1; m_done[i] = 0; m_err[i] = 0; m_eaddr[i] = 0; m_cnt[i] = 0;
      end else if (m_load[i] && in_valid) begin
        w = ref_word(int'(in_opcode), int'(in_reg_a), int'(in_reg_o), int'(in_imm),
                     int'(in_flag), int'(in_label), ok);
        if (ok) begin
          m_mem[i][m_cnt[i]] = w[7:0];
          m_cnt[i]++;
          if (in_last || m_cnt[i] == depth_of(i)) begin
            m_load[i] = 0; m_done[i] = 1;
          end
        end else begin
          m_load[i] = 0; m_err[i] = 1; m_eaddr[i] = m_cnt[i];
        end
      end
    end
  endtask

  function automatic logic [7:0] fetch_exp(int i, int p);
    return (p < m_cnt[i]) ? m_mem[i][p] : 8'hE0;
  endfunction

  // ---------------------------------------------------------------------------
  // Checking helpers
  // ---------------------------------------------------------------------------
  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(string tag);
    chk({tag, " ready0"},  32'(ready0),    32'(m_load[0]));
    chk({tag, " done0"},   32'(done0),     32'(m_done[0]));
    chk({tag, " error0"},  32'(error0),    32'(m_err[0]));
    chk({tag, " eaddr0"},  32'(err_addr0), 32'(m_eaddr[0]));
    chk({tag, " count0"},  32'(count0),    32'(m_cnt[0]));
    chk({tag, " instr0"},  32'(instr0),    32'(fetch_exp(0, int'(pc))));
    chk({tag, " ready1"},  32'(ready1),    32'(m_load[1]));
    chk({tag, " done1"},   32'(done1),     32'(m_done[1]));
    chk({tag, " error1"},  32'(error1),    32'(m_err[1]));
    chk({tag, " eaddr1"},  32'(err_addr1), 32'(m_eaddr[1]));
    chk({tag, " count1"},  32'(count1),    32'(m_cnt[1]));
    chk({tag, " instr1"},  32'(instr1),    32'(fetch_exp(1, int'(pc))));
  endtask

  task automatic sweep(string tag, int n);
    for (int p = 0; p < n; p++) begin
      pc = 16'(p);
      #1;
      chk($sformatf("%s pc%0d u0", tag, p), 32'(instr0), 32'(fetch_exp(0, p)));
      chk($sformatf("%s pc%0d u1", tag, p), 32'(instr1), 32'(fetch_exp(1, p)));
    end
  endtask

  task automatic fetch_is(string tag, int p, logic [7:0] exp);
    pc = 16'(p);
    #1;
    chk(tag, 32'(instr0), 32'(exp));
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus helpers
  // ---------------------------------------------------------------------------
  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic send(int op, int a, int o, int imm, int f, int lbl, bit last, string tag);
    in_opcode = 4'(op); in_reg_a = 3'(a); in_reg_o = 3'(o); in_imm = 3'(imm);
    in_flag = 1'(f); in_label = 4'(lbl); in_last = last; in_valid = 1'b1;
    tick();
    in_valid = 1'b0; in_last = 1'b0;
    check_all(tag);
  endtask

  // ---------------------------------------------------------------------------
  // Directed and random sequence
  // ---------------------------------------------------------------------------
  initial begin
    reset = 1'b1; start = 1'b0; in_valid = 1'b0; in_last = 1'b0; in_flag = 1'b0;
    in_opcode = '0; in_label = '0; in_reg_a = '0; in_reg_o = '0; in_imm = '0; pc = '0;
    tick(); tick();
    reset = 1'b0;

    // Reset state
    check_all("reset");
    chk("reset ready", 32'(ready0), 32'd0);
    chk("reset count", 32'(count0), 32'd0);
    for (int p = 0; p < 6; p++) fetch_is($sformatf("reset pc%0d", p), p, 8'hE0);

    // M-form back-to-back
    do_start();
    check_all("m start");
    chk("m ready after start", 32'(ready0), 32'd1);
    send(4'h0, 3, 4, 0, 0, 0, 1'b0, "m b0");
    send(4'h1, 2, 4, 0, 0, 0, 1'b0, "m b1");
    send(4'h3, 1, 7, 0, 0, 0, 1'b0, "m b2");
    chk("m done before last", 32'(done0), 32'd0);
    send(4'h0, 0, 5, 0, 0, 0, 1'b1, "m b3");
    chk("m done after last", 32'(done0), 32'd1);
    chk("m count", 32'(count0), 32'd4);
    fetch_is("m pc0", 0, 8'h0C);
    fetch_is("m pc1", 1, 8'h18);
    fetch_is("m pc2", 2, 8'h37);
    fetch_is("m pc3", 3, 8'h01);
    fetch_is("m pc4", 4, 8'hE0);
    sweep("m", 6);

    // Mixed forms with gaps
    do_start();
    send(4'h4, 0, 2, 1, 0, 0, 1'b0, "x b0"); tick(); check_all("x gap0");
    send(4'hD, 2, 0, 0, 0, 0, 1'b0, "x b1"); tick(); check_all("x gap1");
    send(4'h4, 0, 3, 1, 0, 0, 1'b0, "x b2"); tick(); check_all("x gap2");
    send(4'h9, 2, 0, 0, 0, 0, 1'b0, "x b3"); tick(); check_all("x gap3");
    send(4'h6, 2, 6, 0, 0, 0, 1'b0, "x b4"); tick(); check_all("x gap4");
    send(4'hE, 0, 0, 0, 0, 0, 1'b1, "x b5");
    fetch_is("x pc0", 0, 8'h42);
    fetch_is("x pc1", 1, 8'hD4);
    fetch_is("x pc2", 2, 8'h43);
    fetch_is("x pc3", 3, 8'h94);
    fetch_is("x pc4", 4, 8'h6A);
    fetch_is("x pc5", 5, 8'hE0);
    chk("x count", 32'(count0), 32'd6);
    chk("x small full", 32'(count1), 32'd4);
    sweep("x", 8);

    // Illegal M-form at beat 2
    do_start();
    send(4'h0, 0, 4, 0, 0, 0, 1'b0, "e b0");
    send(4'h1, 1, 5, 0, 0, 0, 1'b0, "e b1");
    send(4'h7, 4, 5, 0, 0, 0, 1'b0, "e b2");
    chk("e error", 32'(error0), 32'd1);
    chk("e err_addr", 32'(err_addr0), 32'd2);
    chk("e count", 32'(count0), 32'd2);
    fetch_is("e pc2", 2, 8'hE0);
    send(4'h0, 0, 4, 0, 0, 0, 1'b0, "e after");
    chk("e sticky count", 32'(count0), 32'd2);

    // JMP label range
    do_start();
    send(4'h2, 0, 0, 0, 0, 3, 1'b0, "j bad");
    chk("j error", 32'(error0), 32'd1);
    chk("j err_addr", 32'(err_addr0), 32'd0);
    do_start();
    check_all("j restart");
    send(4'h2, 0, 0, 0, 0, 2, 1'b1, "j ok");
    fetch_is("j pc0", 0, 8'h22);
    chk("j done", 32'(done0), 32'd1);

    // Fill the 4-word instance without in_last
    do_start();
    for (int k = 0; k < 6; k++) begin
      send(4'h5, k % 4, 4 + k % 4, 0, 0, 0, 1'b0, $sformatf("f b%0d", k));
      if (k == 3) begin
        chk("f small done", 32'(done1), 32'd1);
        chk("f small ready", 32'(ready1), 32'd0);
        chk("f small count", 32'(count1), 32'd4);
      end
    end
    chk("f small count end", 32'(count1), 32'd4);
    chk("f big count", 32'(count0), 32'd6);
    sweep("f", 8);

    // Restart mid-load discards the beat presented with start
    do_start();
    send(4'h0, 0, 4, 0, 0, 0, 1'b0, "r b0");
    send(4'h0, 1, 4, 0, 0, 0, 1'b0, "r b1");
    send(4'h0, 2, 4, 0, 0, 0, 1'b0, "r b2");
    start = 1'b1; in_valid = 1'b1; in_opcode = 4'h0; in_reg_a = 3'd3; in_reg_o = 3'd7;
    tick();
    start = 1'b0; in_valid = 1'b0;
    check_all("r restart");
    chk("r count zero", 32'(count0), 32'd0);
    send(4'hF, 0, 0, 0, 0, 0, 1'b0, "r n0");
    send(4'h4, 0, 3, 5, 0, 0, 1'b1, "r n1");
    fetch_is("r pc2", 2, 8'hE0);
    fetch_is("r pc1", 1, 8'h4B);
    sweep("r", 4);

    // Reset during LOAD, with start also high: reset wins
    do_start();
    send(4'h0, 0, 4, 0, 0, 0, 1'b0, "z b0");
    reset = 1'b1; start = 1'b1; in_valid = 1'b1;
    tick();
    reset = 1'b0; start = 1'b0; in_valid = 1'b0;
    check_all("z after reset");
    chk("z ready", 32'(ready0), 32'd0);
    chk("z count", 32'(count0), 32'd0);
    sweep("z", 4);

    // Random loads against the model
    for (int r = 0; r < 6; r++) begin
      do_start();
      for (int k = 0; k < 40; k++) begin
        in_valid  = ($urandom_range(0, 9) < 7);
        in_opcode = 4'($urandom);
        in_reg_a  = 3'($urandom);
        in_reg_o  = 3'($urandom);
        in_imm    = 3'($urandom);
        in_flag   = 1'($urandom);
        in_label  = 4'($urandom);
        in_last   = ($urandom_range(0, 15) == 0);
        if ($urandom_range(0, 3) != 0) begin
          in_reg_a[2] = 1'b0;
          in_reg_o[2] = 1'b1;
          if (in_opcode == 4'h4) in_reg_o = 3'(2 + $urandom_range(0, 1));
          if (in_opcode == 4'h2) in_label = 4'($urandom_range(0, 2));
        end
        start = ($urandom_range(0, 31) == 0);
        pc    = 16'($urandom_range(0, 47));
        tick();
        start = 1'b0;
        check_all($sformatf("rnd%0d.%0d", r, k));
      end
      in_valid = 1'b0; in_last = 1'b0;
      sweep($sformatf("rnd%0d", r), 44);
      for (int q = 0; q < 4; q++) begin
        pc = 16'($urandom);
        #1;
        chk($sformatf("rnd%0d far%0d", r, q), 32'(instr0), 32'(fetch_exp(0, int'(pc))));
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
